seq_cla_sub: RTL and testbench
==============================

# seq_cla_sub

- Sequential WIDTH-bit unsigned subtractor with borrow in/out.
- Computes A − B − bin one 4-bit carry-lookahead slice per clock, least-significant slice first, carrying the borrow in a register between slices.
- Valid/ready handshake on both input and output.
- Sits beside the combinational 4-bit lookahead adder as the arithmetic datapath's inverse operation, trading latency for area on wide operands.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result held on diff/bout.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  difference.
- bout  output  1  borrow out; 1 when a < b + bin (unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b, bin; set slice index k=0; borrow register = bin; go to RUN.
- RUN (k = 0 .. WIDTH/4−1):
  - Slice k computes a[4k+3:4k] + ~b[4k+3:4k] + carry, with carry = ~borrow.
  - Use generate/propagate lookahead: G = a & ~b, P = a ^ ~b, with full 4-bit lookahead carries.
  - Write the 4 result bits into diff[4k+3:4k]; borrow register = ~carry_out.
  - k increments; after slice WIDTH/4−1, go to DONE.
- DONE:
  - out_valid=1; diff and bout held stable.
  - bout = final borrow register.
  - On out_ready, go to IDLE.
- Arithmetic: result is (a − b − bin) mod 2^WIDTH, unless SUB_SAT_EN is defined (see Configuration).
- in_valid during RUN or DONE is ignored (in_ready=0); operands must be held by the producer until accepted.
- Unaccepted results are never overwritten or dropped.
- Reset mid-operation (any state): next edge returns to IDLE, discards the in-flight operation, and clears all outputs to reset values.
- diff bits are undefined to the consumer while out_valid=0; reset still clears them.

## Timing
- Reset values:
  - in_ready=1 (after the first reset edge), out_valid=0, diff=0, bout=0.
  - Internal: state=IDLE, k=0, borrow register=0.
- Accept edge = cycle 0. Slice k is written at the edge ending cycle k.
- out_valid rises WIDTH/4 cycles after the accept edge (4 cycles for WIDTH=16).
- out_valid stays high until the first edge where out_ready=1. That edge moves to IDLE; out_valid=0 and in_ready=1 in the following cycle.
- No accept in the same cycle as the output handshake.
- Minimum issue interval: WIDTH/4 + 2 cycles with out_ready tied high.
- out_ready asserted before out_valid has no effect.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SUB_SAT_EN:
  - Defined: saturating subtraction. If the final borrow is 1, diff is forced to 0 when entering DONE; bout still reports 1. Costs one extra mux on the diff register load; latency unchanged.
  - Not defined: diff is the wrapped modulo-2^WIDTH result; no clamp logic is synthesized.

## Test plan
- Simple subtract (WIDTH=16, out_ready=1): a=0x1234, b=0x0234, bin=0 → diff=0x1000, bout=0; out_valid exactly 4 cycles after accept.
- Borrow ripple across all slices: a=0x1000, b=0x0001, bin=0 → diff=0x0FFF, bout=0. Then a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1.
- Underflow with configuration: a=0x0000, b=0x0001 → diff=0xFFFF, bout=1 without SUB_SAT_EN; diff=0x0000, bout=1 with SUB_SAT_EN.
- Backpressure:
  - Result a=0xFFFF, b=0x0F0F → diff=0xF0F0, bout=0.
  - Hold out_ready=0 for 5 cycles: out_valid, diff and bout stable throughout.
  - in_valid with new operands stays unaccepted (in_ready=0) until one cycle after out_ready=1.
- Reset mid-RUN: pull rst_n low for one edge at cycle 2 after accept → next cycle out_valid=0, diff=0, bout=0, in_ready=1. A fresh accept of 0x8000−0x0001 returns 0x7FFF, bout=0.
- Back-to-back random: 1000 random a, b, bin with random in_valid/out_ready gaps → each diff/bout matches the reference model and results arrive in issue order.

Source files
------------

// File: rtl/seq_cla_sub.sv
// Sequential WIDTH-bit subtractor: one 4-bit lookahead slice per clock, LSB slice first.
// Optional macro SUB_SAT_EN clamps diff to zero on underflow (bout still reports it).
module seq_cla_sub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int NSL = WIDTH / 4;
   localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic             borrow_q, borrow_d;

   logic [3:0] sa, snb, g, p, sum;
   logic [4:0] c;

   // Subtraction as a + ~b + ~borrow through a full 4-bit lookahead.
   always_comb begin
      sa   = a_q[{k_q, 2'b00} +: 4];
      snb  = ~b_q[{k_q, 2'b00} +: 4];
      g    = sa & snb;
      p    = sa ^ snb;
      c[0] = ~borrow_q;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[3:0];
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               k_d      = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            diff_d[{k_q, 2'b00} +: 4] = sum;
            borrow_d = ~c[4];
            k_d      = k_q + 1'b1;
            if (k_q == K_LAST) begin
               state_d = DONE;
`ifdef SUB_SAT_EN
               if (borrow_d) diff_d = '0;
`else
`endif
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         k_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign bout      = borrow_q;

endmodule

// File: tb/tb_seq_cla_sub.sv
// Scoreboarded bench for seq_cla_sub: directed cases, backpressure, reset mid-run, random traffic.
module tb_seq_cla_sub;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, bin, out_valid, out_ready, bout;
   logic [W-1:0] a, b, diff;

   int checks   = 0;
   int failures = 0;
   logic [W:0] exp_q[$];

   seq_cla_sub #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mbin);
      int unsigned ia, ib, full;
      logic [W-1:0] d;
      logic         bo;
      ia   = ma;
      ib   = mb;
      full = ib + mbin;
      bo   = (ia < full);
      d    = W'(ia - full);
`ifdef SUB_SAT_EN
      if (bo) d = '0;
`else
`endif
      return {bo, d};
   endfunction

   // Monitor: every output handshake pops the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(diff), 32'hDEAD);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            chk("result", {15'd0, bout, diff}, {15'd0, e});
         end
      end
   end

   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
      int n;
      a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
      exp_q.push_back(model(ta, tb_, tbin));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, cnt, cyc;
      logic acc;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);

      // Simple subtract with latency measurement.
      @(posedge clk); #1 out_ready = 1'b1;
      issue(16'h1234, 16'h0234, 1'b0);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(posedge clk); lat++;
         @(negedge clk);
      end
      chk("latency", 32'(lat), 32'd4);
      drain();

      issue(16'h1000, 16'h0001, 1'b0);
      issue(16'h0005, 16'h0005, 1'b1);
      issue(16'h0000, 16'h0001, 1'b0);
      issue(16'h0000, 16'hFFFF, 1'b1);
      issue(16'hFFFF, 16'h0000, 1'b0);
      drain();

      // Backpressure: result held, new operands wait.
      out_ready = 1'b0;
      issue(16'hFFFF, 16'h0F0F, 1'b0);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
         @(negedge clk); lat++;
      end
      @(posedge clk); #1;
      a = 16'h0003; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_diff", 32'(diff), 32'h0000F0F0);
         chk("bp_bout", 32'(bout), 32'd0);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_hs", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("bp_in_ready_after", 32'(in_ready), 32'd1);
      chk("bp_out_valid_after", 32'(out_valid), 32'd0);
      exp_q.push_back(model(16'h0003, 16'h0001, 1'b0));
      @(posedge clk); #1 in_valid = 1'b0;
      drain();

      // Reset in the middle of RUN.
      issue(16'h1234, 16'h0001, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_diff", 32'(diff), 32'd0);
      chk("midrst_bout", 32'(bout), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      issue(16'h8000, 16'h0001, 1'b0);
      drain();

      // Random traffic with random gaps on both sides.
      cnt = 0; cyc = 0; acc = 1'b0;
      while (cnt < 1000 && cyc < 40000) begin
         @(posedge clk); #1;
         if (acc) begin
            in_valid = 1'b0;
            acc = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (!in_valid && $urandom_range(0, 2) != 0) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            in_valid = 1'b1;
         end
         @(negedge clk);
         if (in_valid && in_ready) begin
            exp_q.push_back(model(a, b, bin));
            acc = 1'b1;
            cnt++;
         end
         cyc++;
      end
      @(posedge clk); #1 in_valid = 1'b0;
      out_ready = 1'b1;
      chk("random_issued", 32'(cnt), 32'd1000);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
